// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader and the writable
// instruction memory: memory geometry and the loader state encoding.
package loader_pkg;

  localparam int unsigned IMEM_DEPTH  = 128;
  localparam int unsigned IMEM_ADDR_W = 7;

  // Loader phases: header byte, data bytes, optional checksum byte, image ready
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage : loader_pkg

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : drop any partial word and restart at lane 0
//   byte_valid_i  : byte_i is accepted this cycle
//   byte_i        : incoming byte
//   lane_o        : lane the next accepted byte will occupy (3 = word-completing byte)
//   word_valid_o  : one-cycle pulse, the cycle after the 4th byte of a word
//   word_o        : assembled word, stable while word_valid_o is high
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q;
  logic        word_valid_q;
  logic [31:0] asm_q, asm_d;

  // Merge the incoming byte into its lane
  always_comb begin
    asm_d = asm_q;
    case (lane_q)
      2'd0:    asm_d[7:0]   = byte_i;
      2'd1:    asm_d[15:8]  = byte_i;
      2'd2:    asm_d[23:16] = byte_i;
      default: asm_d[31:24] = byte_i;
    endcase
  end

  // Lane counter, assembly register and completion strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q       <= 2'd0;
      word_valid_q <= 1'b0;
      asm_q        <= 32'd0;
    end else if (clr_i) begin
      lane_q       <= 2'd0;
      word_valid_q <= 1'b0;
      asm_q        <= 32'd0;
    end else begin
      word_valid_q <= byte_valid_i && (lane_q == 2'd3);
      if (byte_valid_i) begin
        asm_q  <= asm_d;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign lane_o       = lane_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = asm_q;

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Instruction-memory program loader. Takes a length header plus little-endian
// instruction bytes over valid/ready, packs them into 32-bit words, writes the
// instruction memory and holds the core in reset until the image is loaded.
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing XOR
// checksum byte (over header and data) and report a mismatch on err.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : one-cycle pulse, re-arms the loader from DONE
//   in_valid/in_data  : byte stream input
//   in_ready          : loader accepts a byte (registered)
//   wr_en/wr_addr/wr_data : instruction memory write port (registered)
//   cpu_rst_n         : core reset, released only when loaded without error
//   done              : image complete (level)
//   err               : checksum failure (level)
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  // The word index never wraps only if the memory spans the full address space
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("imem_loader: DEPTH must equal 2**ADDR_W");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   n_last_q, n_last_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;

  logic                xfer_c;
  logic                pk_clr_c;
  logic                pk_byte_valid_c;
  logic [1:0]          pk_lane;
  logic                pk_word_valid;
  logic [31:0]         pk_word;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  assign xfer_c          = in_valid && in_ready_q;
  assign pk_clr_c        = xfer_c && (state_q == S_HDR);
  assign pk_byte_valid_c = xfer_c && (state_q == S_DATA);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr_c),
    .byte_valid_i (pk_byte_valid_c),
    .byte_i       (in_data),
    .lane_o       (pk_lane),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    n_last_d   = n_last_q;
    word_idx_d = word_idx_q;
    wr_addr_d  = wr_addr_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif

    case (state_q)
      S_HDR: begin
        if (xfer_c) begin
          n_last_d   = in_data[ADDR_W-1:0];
          word_idx_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = in_data;
`endif
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (xfer_c) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          // Word-completing byte: latch the address that goes out with the strobe
          if (pk_lane == 2'd3) begin
            wr_addr_d = word_idx_q;
            if (word_idx_q == n_last_q) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              word_idx_d = word_idx_q + ADDR_W'(1);
            end
          end
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer_c) begin
          err_d   = (in_data != csum_q);
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        if (start) begin
          state_d = S_HDR;
`ifdef IMEM_LOADER_CSUM_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: state_d = S_HDR;
    endcase

    // done/cpu_rst_n follow the registered state, so they trail the last write
    in_ready_d  = (state_d != S_DONE);
    done_d      = (state_q == S_DONE) && !start;
`ifdef IMEM_LOADER_CSUM_EN
    cpu_rst_n_d = done_d && !err_d;
`else
    cpu_rst_n_d = done_d;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      n_last_q    <= '0;
      word_idx_q  <= '0;
      wr_addr_q   <= '0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_last_q    <= n_last_d;
      word_idx_q  <= word_idx_d;
      wr_addr_q   <= wr_addr_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running checksum and error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign wr_en     = pk_word_valid;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = pk_word;
  assign done      = done_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based model
// of the byte stream and the expected memory write sequence.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_n;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write-port monitor, sampled just after each rising edge
  int          cyc = 0;
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          done_rise = -1;
  logic        done_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    done_prev = done;
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    done_rise = -1;
  endtask

  // Offer one byte starting at a falling edge; returns after it has transferred
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Re-arm from DONE with a one-cycle start pulse
  task automatic rearm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rearm_in_ready", 32'(in_ready), 32'd1);
  endtask

  // mode: 0 random bytes, 1 incrementing, 2 {13 00 00 00}, 3 {01 02 03 04}
  task automatic run_load(input int nw, input bit gaps, input int mode,
                          input bit b2b, input bit start_mid, input bit bad_csum);
    logic [7:0]  hdr, b, x;
    logic [7:0]  bytes[$];
    logic [31:0] exp_word;
    int          t, n_obs;
    clear_obs();
    hdr = (mode == 0) ? {1'($urandom), 7'(nw - 1)} : 8'(nw - 1);
    x   = hdr;
    send_byte(hdr, gaps);
    for (int i = 0; i < 4 * nw; i++) begin
      case (mode)
        1:       b = 8'(i);
        2:       b = (i == 0) ? 8'h13 : 8'h00;
        3:       b = 8'(i + 1);
        default: b = 8'($urandom);
      endcase
      bytes.push_back(b);
      x = x ^ b;
      if (start_mid && i == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_mid_in_ready", 32'(in_ready), 32'd1);
        chk("start_mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("start_mid_done", 32'(done), 32'd0);
      end
      send_byte(b, gaps);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
`endif
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    repeat (6) @(negedge clk);
    n_obs = obs_addr.size();
    chk("wr_count", 32'(n_obs), 32'(nw));
    for (int i = 0; i < nw && i < n_obs; i++) begin
      exp_word = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      chk($sformatf("wr_addr[%0d]", i), 32'(obs_addr[i]), 32'(i));
      chk($sformatf("wr_data[%0d]", i), obs_data[i], exp_word);
      if (b2b && i > 0)
        chk($sformatf("wr_gap[%0d]", i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd4);
    end
`ifndef IMEM_LOADER_CSUM_EN
    if (n_obs == nw)
      chk("done_latency", 32'(done_rise - obs_cyc[nw-1]), 32'd1);
`endif
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_level", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'(bad_csum));
    chk("done_cpu_rst_n", 32'(cpu_rst_n), 32'(!bad_csum));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Single word 0x00000013
    run_load(1, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // Full memory, back-to-back incrementing bytes
    rearm();
    run_load(128, 1'b0, 1, 1'b1, 1'b0, 1'b0);

    // start during DATA is ignored
    rearm();
    run_load(3, 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Random lengths with random in_valid gaps
    for (int k = 0; k < 6; k++) begin
      rearm();
      run_load(int'($urandom_range(1, 8)), 1'b1, 0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of word 1
    rearm();
    clear_obs();
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_writes", 32'(obs_addr.size()), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_writes", 32'(obs_addr.size()), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    run_load(3, 1'b1, 0, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    rearm();
    run_load(1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    rearm();
    run_load(1, 1'b0, 3, 1'b0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_loader
